// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding select
// encodings and the stall FSM state type.
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Combinational operand forwarding: EX-stage ALU operand selects and the
// ID-stage branch comparator bypass from EX/MEM.
module hazard_fwd_sel
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              mem_reg_write,
    input  logic              mem_mem_read,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              fwd_br_a,
    output logic              fwd_br_b
);

    // The newer result in EX/MEM wins over the older one in MEM/WB.
    function automatic logic [1:0] ex_sel(input logic [REG_AW-1:0] src);
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == src))
            return FWD_EXMEM;
        else if (wb_reg_write && (wb_rd != '0) && (wb_rd == src))
            return FWD_MEMWB;
        else
            return FWD_RF;
    endfunction

    assign fwd_a = ex_sel(ex_rs);
    assign fwd_b = ex_sel(ex_rt);

    // A load in MEM has no data yet, so it can never feed the comparator.
    assign fwd_br_a = mem_reg_write && !mem_mem_read && (mem_rd != '0)
                      && id_use_rs && (mem_rd == id_rs);
    assign fwd_br_b = mem_reg_write && !mem_mem_read && (mem_rd != '0)
                      && id_use_rt && (mem_rd == id_rt);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / branch stall FSM, flush and forwarding.
// Define HAZARD_PERF_EN to add stall_cycles / flush_count performance counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW          = 5,
    parameter int LOAD_USE_STALLS = 1,
    parameter int ALU_BR_STALLS   = 1,
    parameter int LOAD_BR_STALLS  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_branch,
    input  logic              id_br_taken,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              mem_reg_write,
    input  logic              mem_mem_read,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_bubble,
    output logic              if_id_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              fwd_br_a,
    output logic              fwd_br_b,
`ifdef HAZARD_PERF_EN
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_count,
`endif
    output logic              busy
);

    localparam int MAX_A      = (LOAD_USE_STALLS > ALU_BR_STALLS) ? LOAD_USE_STALLS : ALU_BR_STALLS;
    localparam int MAX_B      = (MAX_A > LOAD_BR_STALLS) ? MAX_A : LOAD_BR_STALLS;
    localparam int MAX_STALLS = (MAX_B > 1) ? MAX_B : 1;
    localparam int CNT_W      = $clog2(MAX_STALLS) + 1;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] n_req;
    logic             ex_hit;
    logic             mem_load_hit;
    logic             stall;

    hazard_fwd_sel #(
        .REG_AW(REG_AW)
    ) u_fwd_sel (
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .mem_reg_write(mem_reg_write),
        .mem_mem_read (mem_mem_read),
        .mem_rd       (mem_rd),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .fwd_br_a     (fwd_br_a),
        .fwd_br_b     (fwd_br_b)
    );

    assign ex_hit = ex_reg_write && (ex_rd != '0)
                    && ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

    assign mem_load_hit = id_branch && mem_reg_write && mem_mem_read && (mem_rd != '0)
                          && ((id_use_rs && (id_rs == mem_rd)) || (id_use_rt && (id_rt == mem_rd)));

    // Bubble demand of the ID instruction; a load in MEM feeding a branch needs one.
    always_comb begin
        n_req = '0;
        if (ex_hit) begin
            unique case ({id_branch, ex_mem_read})
                2'b11:   n_req = CNT_W'(LOAD_BR_STALLS);
                2'b10:   n_req = CNT_W'(ALU_BR_STALLS);
                2'b01:   n_req = CNT_W'(LOAD_USE_STALLS);
                default: n_req = '0;
            endcase
        end
        if (mem_load_hit && (n_req == '0))
            n_req = CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (n_req != '0) begin
                    stall    = 1'b1;
                    cnt_next = n_req - CNT_W'(1);
                    if (n_req > CNT_W'(1))
                        state_next = STALL;
                end
            end
            STALL: begin
                stall = 1'b1;
                if (cnt <= CNT_W'(1)) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign pc_write     = !stall;
    assign if_id_write  = !stall;
    assign id_ex_bubble = stall;
    assign if_id_flush  = id_branch && id_br_taken && !stall;
    assign busy         = (state == STALL);

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall)
                stall_cycles <= stall_cycles + 32'd1;
            if (if_id_flush)
                flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule
